// File: rtl/image_bit_loader_if.sv
// Bundle of the UART byte input, SNN core handshake and 1-bit input-RAM write port.
// The loader connects through 'slave'; whatever drives bytes and watches the RAM uses 'master'.
interface image_bit_loader_if;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic       core_done;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_wdata;
    logic       start;
    logic       frame_err;
    logic       ovfl;
    logic [6:0] byte_cnt;

    modport master (
        output rx_rdy, rx_data, core_done,
        input  ram_we, ram_addr, ram_wdata, start, frame_err, ovfl, byte_cnt
    );

    modport slave (
        input  rx_rdy, rx_data, core_done,
        output ram_we, ram_addr, ram_wdata, start, frame_err, ovfl, byte_cnt
    );
endinterface

// File: rtl/image_bit_loader.sv
// Unpacks UART bytes LSB-first into a 1-bit image RAM, one bit per cycle, then starts the SNN core.
// A 2-entry byte FIFO absorbs back-to-back bytes; a mid-frame idle timeout aborts partial images.
module image_bit_loader #(
    parameter int NUM_BYTES      = 98,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input logic          clk,
    input logic          rst_n,
    image_bit_loader_if.slave bus
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_SHIFT     = 2'd1;
    localparam logic [1:0] S_START     = 2'd2;
    localparam logic [1:0] S_WAIT_CORE = 2'd3;

    localparam int          TW           = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]  NUM_BYTES_W  = 7'(NUM_BYTES);
    localparam logic [6:0]  LAST_BYTE_W  = 7'(NUM_BYTES - 1);

    logic [1:0]    r_state;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bit_idx;
    logic [6:0]    r_byte_cnt;
    logic [TW-1:0] r_to_cnt;

    logic [7:0]    r_fifo_mem [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    logic [1:0]    r_fifo_cnt;

    logic          w_fifo_empty;
    logic          w_fifo_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [7:0]    w_fifo_head;
    logic          w_to_run;
    logic          w_to_expire;
    logic          w_in_shift;

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    assign w_fifo_empty = (r_fifo_cnt == 2'd0);
    assign w_fifo_full  = (r_fifo_cnt == 2'd2);
    assign w_fifo_head  = r_fifo_mem[r_rd_ptr];

    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign w_pop  = (r_state == S_IDLE) && !w_fifo_empty;
    assign w_push = bus.rx_rdy && (!w_fifo_full || w_pop);
    assign w_drop = bus.rx_rdy && w_fifo_full && !w_pop;

    // NOTE: storage needs no reset -- the pointers/count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Mid-frame idle timeout
    // ------------------------------------------------------------------
    assign w_to_run    = (r_state == S_IDLE) && w_fifo_empty &&
                         (r_byte_cnt != 7'd0) && (r_byte_cnt < NUM_BYTES_W);
    assign w_to_expire = w_to_run && (r_to_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (w_pop || !w_to_run || w_to_expire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM and bit shifter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shreg    <= 8'd0;
            r_bit_idx  <= 3'd0;
            r_byte_cnt <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shreg   <= w_fifo_head;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_SHIFT;
                    end else if (w_to_expire) begin
                        r_byte_cnt <= 7'd0;
                    end
                end
                S_SHIFT: begin
                    r_shreg   <= {1'b0, r_shreg[7:1]};
                    r_bit_idx <= r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        r_byte_cnt <= r_byte_cnt + 7'd1;
                        r_state    <= (r_byte_cnt == LAST_BYTE_W) ? S_START : S_IDLE;
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_CORE;
                end
                S_WAIT_CORE: begin
                    if (bus.core_done) begin
                        r_byte_cnt <= 7'd0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Address/data are forced to 0 outside SHIFT so the bus idles clean and never shows 784.
    assign w_in_shift    = (r_state == S_SHIFT);
    assign bus.ram_we    = w_in_shift;
    assign bus.ram_addr  = w_in_shift ? {r_byte_cnt, r_bit_idx} : 10'd0;
    assign bus.ram_wdata = w_in_shift & r_shreg[0];
    assign bus.start     = (r_state == S_START);
    assign bus.frame_err = w_to_expire;
    assign bus.ovfl      = w_drop;
    assign bus.byte_cnt  = r_byte_cnt;

endmodule

// File: tb/tb_image_bit_loader.sv
// Self-checking bench for image_bit_loader: byte table + write scoreboard, plus hand sequences
// for latency, FIFO overflow, core handshake, timeout abort and reset mid-shift.
module tb_image_bit_loader;

    typedef struct packed {
        logic [9:0] addr;
        logic       data;
    } wr_t;

    // seq lists the expected RAM bits in write order: seq[7] goes to the lowest address.
    typedef struct packed {
        logic [7:0] data;
        logic [7:0] seq;
    } vec_t;

    logic clk;
    logic rst_n;
    image_bit_loader_if bus();

    image_bit_loader #(.NUM_BYTES(98), .TIMEOUT_CYCLES(100)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_start = 0;
    int   n_ovfl  = 0;
    int   n_ferr  = 0;
    logic prev_783 = 1'b0;
    wr_t  sb_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_byte(input int idx, input logic [7:0] seq);
        for (int k = 0; k < 8; k++) begin
            wr_t w;
            w.addr = 10'(idx * 8 + k);
            w.data = seq[7-k];
            sb_q.push_back(w);
        end
    endtask

    // Scoreboard monitor and pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ram_we) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_write_addr", 32'(bus.ram_addr), 32'h3ff);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.ram_wdata), 32'(e.data));
                end
            end
            if (bus.start || prev_783) begin
                check("start_after_addr783", 32'(bus.start), 32'(prev_783));
            end
            if (bus.start)     n_start++;
            if (bus.ovfl)      n_ovfl++;
            if (bus.frame_err) n_ferr++;
            prev_783 <= bus.ram_we && (bus.ram_addr == 10'd783);
        end else begin
            prev_783 <= 1'b0;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_we",    32'(bus.ram_we),    0);
        check("rst_ram_addr",  32'(bus.ram_addr),  0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 0);
        check("rst_start",     32'(bus.start),     0);
        check("rst_frame_err", 32'(bus.frame_err), 0);
        check("rst_ovfl",      32'(bus.ovfl),      0);
        check("rst_byte_cnt",  32'(bus.byte_cnt),  0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = b;
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
    endtask

    task automatic pulse_core_done();
        @(posedge clk);
        #1;
        bus.core_done = 1'b1;
        @(posedge clk);
        #1;
        bus.core_done = 1'b0;
    endtask

    task automatic send_run(input int first_idx, input int count, input int voff, input int gap);
        for (int i = 0; i < count; i++) begin
            vec_t v;
            v = vecs[(voff + i) % 8];
            expect_byte(first_idx + i, v.seq);
            send_byte(v.data);
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb_q.size()), 0);
        sb_q.delete();
    endtask

    initial begin
        int s0;
        int n;

        vecs[0] = '{data: 8'hA5, seq: 8'b1010_0101};
        vecs[1] = '{data: 8'h01, seq: 8'b1000_0000};
        vecs[2] = '{data: 8'h80, seq: 8'b0000_0001};
        vecs[3] = '{data: 8'hFF, seq: 8'b1111_1111};
        vecs[4] = '{data: 8'h00, seq: 8'b0000_0000};
        vecs[5] = '{data: 8'h3C, seq: 8'b0011_1100};
        vecs[6] = '{data: 8'h0F, seq: 8'b1111_0000};
        vecs[7] = '{data: 8'h96, seq: 8'b0110_1001};

        rst_n         = 1'b0;
        bus.rx_rdy    = 1'b0;
        bus.rx_data   = 8'h00;
        bus.core_done = 1'b0;
        do_reset();

        // Back-to-back bytes in IDLE: both accepted, no overflow.
        expect_byte(0, vecs[1].seq);
        expect_byte(1, vecs[2].seq);
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = 8'h01;
        @(posedge clk);
        #1;
        bus.rx_data = 8'h80;
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
        drain("b2b_drain", 60);
        check("b2b_no_ovfl", 32'(n_ovfl), 0);

        // Latency: rx_rdy into an empty FIFO -> first write two cycles later.
        expect_byte(2, vecs[0].seq);
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b1;
        bus.rx_data = vecs[0].data;
        @(posedge clk);
        #1;
        bus.rx_rdy  = 1'b0;
        check("lat_cycle1_we", 32'(bus.ram_we), 0);
        @(posedge clk);
        #1;
        check("lat_cycle2_we",   32'(bus.ram_we),   1);
        check("lat_cycle2_addr", 32'(bus.ram_addr), 16);
        drain("lat_drain", 30);

        // Table-driven bytes to reach byte_cnt 40.
        send_run(3, 37, 1, 12);
        drain("table_drain", 60);
        @(posedge clk);
        #1;
        check("byte_cnt_40", 32'(bus.byte_cnt), 40);

        // core_done outside WAIT_CORE is ignored.
        s0 = n_start;
        pulse_core_done();
        repeat (3) @(posedge clk);
        #1;
        check("ign_core_done_cnt", 32'(bus.byte_cnt), 40);
        check("ign_core_done_we",  32'(bus.ram_we),   0);
        check("ign_core_done_start", 32'(n_start - s0), 0);

        // Mid-frame timeout after 5 bytes.
        do_reset();
        send_run(0, 4, 2, 12);
        expect_byte(4, vecs[6].seq);
        send_byte(vecs[6].data);
        n = 0;
        while (!(bus.ram_we && bus.ram_addr == 10'd39) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("to_last_write_seen", 32'(n < 60), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_err && n < 200);
        check("to_idle_cycles", 32'(n), 100);
        @(posedge clk);
        #1;
        check("to_byte_cnt", 32'(bus.byte_cnt), 0);
        check("to_ferr_count", 32'(n_ferr), 1);
        send_run(0, 1, 3, 0);
        drain("to_restart_drain", 30);
        @(posedge clk);
        #1;
        check("to_restart_cnt", 32'(bus.byte_cnt), 1);

        // Full image of 0xA5, then overflow and core handshake in WAIT_CORE.
        do_reset();
        s0 = n_start;
        for (int i = 0; i < 98; i++) begin
            expect_byte(i, vecs[0].seq);
            send_byte(8'hA5);
            repeat (12) @(posedge clk);
        end
        drain("img_drain", 60);
        repeat (3) @(posedge clk);
        #1;
        check("img_start_count", 32'(n_start - s0), 1);
        check("img_byte_cnt",    32'(bus.byte_cnt), 98);

        s0 = n_ovfl;
        expect_byte(0, vecs[6].seq);
        expect_byte(1, vecs[7].seq);
        send_byte(vecs[6].data);
        send_byte(vecs[7].data);
        check("wait_no_ovfl_2", 32'(n_ovfl - s0), 0);
        send_byte(8'hFF);
        check("wait_ovfl_3", 32'(n_ovfl - s0), 1);
        repeat (5) @(posedge clk);
        #1;
        check("wait_no_write", 32'(bus.ram_we), 0);
        pulse_core_done();
        drain("wait_drain", 60);
        @(posedge clk);
        #1;
        check("wait_byte_cnt", 32'(bus.byte_cnt), 2);

        // Reset in the third SHIFT cycle of byte 10.
        do_reset();
        send_run(0, 10, 0, 12);
        drain("rst_pre_drain", 60);
        expect_byte(10, vecs[2].seq);
        send_byte(vecs[2].data);
        n = 0;
        while (!(bus.ram_we && bus.ram_addr == 10'd82) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_seen", 32'(n < 40), 1);
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("rst_mid_we",    32'(bus.ram_we),   0);
        check("rst_mid_cnt",   32'(bus.byte_cnt), 0);
        check("rst_mid_start", 32'(bus.start),    0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        s0 = n_start;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_no_start", 32'(n_start - s0), 0);
        send_run(0, 1, 5, 0);
        drain("rst_mid_restart", 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/image_bit_loader.md
IMAGE_BIT_LOADER -- requirements
Module: image_bit_loader

Interface
REQ-001 Parameter NUM_BYTES, default 98, meaning bytes per image (784 pixel bits).
REQ-002 Parameter TIMEOUT_CYCLES, default 5000000, meaning idle cycles mid-frame before abort (100 ms at 50 MHz).
REQ-003 The block SHALL have one clock and an asynchronous active-low reset; ports listed below.
REQ-004 clk  input  1  system clock, 50 MHz, all state on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset, pre-synchronized.
REQ-006 rx_rdy  input  1  one-cycle pulse, rx_data valid.
REQ-007 rx_data  input  8  received UART byte, pixel bits LSB-first.
REQ-008 core_done  input  1  one-cycle pulse from the SNN core at end of classification.
REQ-009 ram_we  output  1  write enable to the 1-bit x 1024 input RAM.
REQ-010 ram_addr  output  10  RAM write address.
REQ-011 ram_wdata  output  1  RAM write data.
REQ-012 start  output  1  one-cycle pulse; image complete, core may run.
REQ-013 frame_err  output  1  one-cycle pulse on mid-frame timeout.
REQ-014 ovfl  output  1  one-cycle pulse when a received byte is dropped.
REQ-015 byte_cnt  output  7  bytes of current image fully written, 0..NUM_BYTES.

Function
REQ-016 The block SHALL buffer bytes in a 2-entry FIFO; push on rx_rdy, pop by FSM.
REQ-017 Push with FIFO full and no same-cycle pop SHALL drop the byte and pulse ovfl; push and pop in the same cycle with FIFO full SHALL accept the byte.
REQ-018 FSM states SHALL be IDLE, SHIFT, START, WAIT_CORE.
REQ-019 IDLE: FIFO non-empty -> pop head into an 8-bit shift register, clear bit_idx, go SHIFT next cycle.
REQ-020 SHIFT: each cycle ram_we=1, ram_wdata=shreg[0], ram_addr=byte_cnt*8+bit_idx; then shreg>>1, bit_idx+1.
REQ-021 SHIFT SHALL last exactly 8 cycles per byte; after bit_idx 7 byte_cnt increments.
REQ-022 After bit 7 with byte_cnt becoming NUM_BYTES (last address 783): go START; otherwise go IDLE.
REQ-023 START: start=1 for exactly one cycle, go WAIT_CORE.
REQ-024 WAIT_CORE: ram_we=0; bytes still enter the FIFO (max 2 held, extras dropped per REQ-017); core_done -> byte_cnt=0, go IDLE.
REQ-025 ram_we SHALL be 0 in every state other than SHIFT; ram_addr SHALL never exceed NUM_BYTES*8-1.
REQ-026 Latency: rx_rdy into empty FIFO in IDLE -> first ram_we 2 cycles later; last write of image -> start next cycle.
REQ-027 Timeout counter SHALL run only in IDLE with 0<byte_cnt<NUM_BYTES and FIFO empty, and SHALL clear on any pop or when not running.
REQ-028 Counter reaching TIMEOUT_CYCLES-1 SHALL pulse frame_err, clear byte_cnt to 0, stay IDLE.
REQ-029 core_done outside WAIT_CORE SHALL be ignored.

Reset
REQ-030 On rst_n low, asynchronously: state IDLE, FIFO empty, byte_cnt 0, bit_idx 0, timeout counter 0.
REQ-031 During and after reset: ram_we 0, ram_addr 0, ram_wdata 0, start 0, frame_err 0, ovfl 0.
REQ-032 Reset mid-SHIFT or mid-WAIT_CORE SHALL abort with no further RAM write; next image starts at address 0.

Verification
REQ-033 98 bytes 0xA5, 4340 cycles apart -> 784 writes, addr 0..783, data pattern 1,0,1,0,0,1,0,1 per byte, one start pulse after addr 783.
REQ-034 rx_rdy on two consecutive cycles (0x01, 0x80) in IDLE -> both written: addr 0 data 1, addr 15 data 1, others 0, no ovfl.
REQ-035 Three rx_rdy pulses in WAIT_CORE -> ovfl once on third; after core_done the two held bytes land at addr 0..15.
REQ-036 TIMEOUT_CYCLES=100, send 5 bytes then silence -> frame_err after 100 idle cycles, byte_cnt 0, next byte written at addr 0.
REQ-037 rst_n low during 3rd SHIFT cycle of byte 10 -> ram_we 0 immediately, byte_cnt 0, no start.
REQ-038 core_done pulse in IDLE with byte_cnt 40 -> no state change, byte_cnt stays 40.
